// File: rtl/icebus_status_rx.sv
// iCEboard status link receiver: 8N1 UART front end, frame parser with
// CRC16-CCITT check, decoded encoder outputs and link-quality counters.
module icebus_status_rx #(
  parameter int NUMBER_OF_MOTORS = 8,
  parameter int CLOCK_FREQ_HZ    = 50_000_000,
  parameter int BAUDRATE         = 1_000_000,
  parameter int TIMEOUT_BITS     = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_i,
  output logic               status_valid,
  output logic [7:0]         status_motor,
  output logic signed [31:0] encoder0_position,
  output logic signed [31:0] encoder1_position,
  output logic signed [31:0] encoder0_velocity,
  output logic signed [31:0] encoder1_velocity,
  output logic [15:0]        frames_ok,
  output logic [15:0]        frames_bad
);

  // Bit timing; the integer ratio is expected to be at least 8.
  localparam int CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUDRATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDLE_CNT_W   = $clog2(TIMEOUT_CLKS);

  localparam logic [BIT_CNT_W-1:0]  BIT_LAST     = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0]  HALF_LAST    = BIT_CNT_W'(HALF_BIT - 1);
  localparam logic [IDLE_CNT_W-1:0] TIMEOUT_LAST = IDLE_CNT_W'(TIMEOUT_CLKS - 1);

  // UART receiver states
  localparam logic [1:0] U_IDLE  = 2'd0;
  localparam logic [1:0] U_START = 2'd1;
  localparam logic [1:0] U_DATA  = 2'd2;
  localparam logic [1:0] U_STOP  = 2'd3;

  // Frame parser states
  localparam logic [2:0] P_SYNC0   = 3'd0;
  localparam logic [2:0] P_SYNC1   = 3'd1;
  localparam logic [2:0] P_ID      = 3'd2;
  localparam logic [2:0] P_PAYLOAD = 3'd3;
  localparam logic [2:0] P_CRC_HI  = 3'd4;
  localparam logic [2:0] P_CRC_LO  = 3'd5;

  // CRC16-CCITT (poly 0x1021, MSB first) advanced by one whole byte.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Saturating increment for the link-quality counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

  logic                  rx_p0;
  logic                  rx_p1;
  logic                  rx_p2;
  logic [1:0]            u_state;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shift_reg;
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  framing_err;

  logic [2:0]            p_state;
  logic [3:0]            byte_idx;
  logic [IDLE_CNT_W-1:0] idle_cnt;
  logic [7:0]            motor_id;
  logic [127:0]          staging;
  logic [15:0]           crc;
  logic [7:0]            crc_hi;
  logic                  in_frame;
  logic                  id_ok;
  logic                  crc_ok;

  assign in_frame = (p_state != P_SYNC0) && (p_state != P_SYNC1);
  assign id_ok    = (32'(motor_id) < 32'(NUMBER_OF_MOTORS));
  assign crc_ok   = ({crc_hi, byte_data} == crc);

  // Stage p0/p1: two-flop synchronizer; p2 holds the previous level for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx_i;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // UART bit engine: mid-bit sampling, LSB first, one-cycle byte/framing pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      u_state     <= U_IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
      case (u_state)
        U_IDLE: begin
          if (rx_p2 && !rx_p1) begin
            u_state <= U_START;
            bit_cnt <= '0;
          end
        end
        U_START: begin
          if (bit_cnt == HALF_LAST) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            u_state <= rx_p1 ? U_IDLE : U_DATA;
          end else begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          end
        end
        U_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt   <= '0;
            shift_reg <= {rx_p1, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              u_state <= U_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          end
        end
        U_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            u_state <= U_IDLE;
            if (rx_p1) begin
              byte_valid <= 1'b1;
              byte_data  <= shift_reg;
            end else begin
              framing_err <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          end
        end
        default: u_state <= U_IDLE;
      endcase
    end
  end

  // Parser datapath: ID latch, payload staging and running CRC (no reset needed).
  always_ff @(posedge clk) begin
    if (byte_valid) begin
      case (p_state)
        P_ID: begin
          motor_id <= byte_data;
          crc      <= crc16_byte(16'hFFFF, byte_data);
        end
        P_PAYLOAD: begin
          staging <= {staging[119:0], byte_data};
          crc     <= crc16_byte(crc, byte_data);
        end
        P_CRC_HI: crc_hi <= byte_data;
        default: ;
      endcase
    end
  end

  // Parser control: sync hunt, frame sequencing, timeout, commit and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_state           <= P_SYNC0;
      byte_idx          <= '0;
      idle_cnt          <= '0;
      status_valid      <= 1'b0;
      status_motor      <= '0;
      encoder0_position <= '0;
      encoder1_position <= '0;
      encoder0_velocity <= '0;
      encoder1_velocity <= '0;
      frames_ok         <= '0;
      frames_bad        <= '0;
    end else begin
      status_valid <= 1'b0;

      if (!in_frame || byte_valid) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
      end

      if (framing_err) begin
        // A broken byte only costs a bad frame once the frame has really started.
        if (in_frame) frames_bad <= sat_inc16(frames_bad);
        p_state <= P_SYNC0;
      end else if (in_frame && !byte_valid && idle_cnt == TIMEOUT_LAST) begin
        frames_bad <= sat_inc16(frames_bad);
        p_state    <= P_SYNC0;
      end else if (byte_valid) begin
        case (p_state)
          P_SYNC0: begin
            if (byte_data == 8'hAA) p_state <= P_SYNC1;
          end
          P_SYNC1: begin
            if (byte_data == 8'h55)      p_state <= P_ID;
            else if (byte_data != 8'hAA) p_state <= P_SYNC0;
          end
          P_ID: begin
            byte_idx <= '0;
            p_state  <= P_PAYLOAD;
          end
          P_PAYLOAD: begin
            if (byte_idx == 4'd15) p_state <= P_CRC_HI;
            else                   byte_idx <= byte_idx + 4'd1;
          end
          P_CRC_HI: p_state <= P_CRC_LO;
          P_CRC_LO: begin
            if (crc_ok && id_ok) begin
              status_valid      <= 1'b1;
              status_motor      <= motor_id;
              encoder0_position <= $signed(staging[127:96]);
              encoder1_position <= $signed(staging[95:64]);
              encoder0_velocity <= $signed(staging[63:32]);
              encoder1_velocity <= $signed(staging[31:0]);
              frames_ok         <= sat_inc16(frames_ok);
            end else begin
              frames_bad <= sat_inc16(frames_bad);
            end
            p_state <= P_SYNC0;
          end
          default: p_state <= P_SYNC0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icebus_status_rx.sv
// Directed bench for icebus_status_rx with a scoreboard of expected commits.
module tb_icebus_status_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  typedef struct packed {
    logic [7:0]  motor;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] v0;
    logic [31:0] v1;
  } rec_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               rx_i;
  logic               status_valid;
  logic [7:0]         status_motor;
  logic signed [31:0] encoder0_position;
  logic signed [31:0] encoder1_position;
  logic signed [31:0] encoder0_velocity;
  logic signed [31:0] encoder1_velocity;
  logic [15:0]        frames_ok;
  logic [15:0]        frames_bad;

  int   tests = 0;
  int   errs = 0;
  int   pulses = 0;
  int   exp_pulses = 0;
  int   byte_cnt = 0;
  logic [7:0] last_byte = 8'h00;
  time  stop_t = 0;
  time  pulse_t = 0;
  rec_t exp_q[$];
  rec_t last_rec = '0;

  icebus_status_rx #(
    .NUMBER_OF_MOTORS(8),
    .CLOCK_FREQ_HZ(16_000_000),
    .BAUDRATE(1_000_000),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_i(rx_i),
    .status_valid(status_valid),
    .status_motor(status_motor),
    .encoder0_position(encoder0_position),
    .encoder1_position(encoder1_position),
    .encoder0_velocity(encoder0_velocity),
    .encoder1_velocity(encoder1_velocity),
    .frames_ok(frames_ok),
    .frames_bad(frames_bad)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Bit-serial reference CRC16-CCITT.
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic bit_time(input logic v);
    rx_i = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    stop_t = $time;
    bit_time(stop_bit);
  endtask

  task automatic idle_bits(input int n);
    rx_i = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  // Sends bytes [first, n_bytes) of a frame; byte bad_stop gets a low stop bit.
  task automatic send_frame(input logic [7:0] id, input logic [31:0] p0, input logic [31:0] p1,
                            input logic [31:0] v0, input logic [31:0] v1, input logic [7:0] crc_xor,
                            input int first, input int n_bytes, input int bad_stop);
    logic [7:0]   fr[21];
    logic [127:0] pay;
    logic [15:0]  c;
    pay   = {p0, p1, v0, v1};
    fr[0] = 8'hAA;
    fr[1] = 8'h55;
    fr[2] = id;
    for (int k = 0; k < 16; k++) fr[3 + k] = pay[127 - 8 * k -: 8];
    c = 16'hFFFF;
    for (int k = 2; k < 19; k++) c = crc_ref(c, fr[k]);
    fr[19] = c[15:8];
    fr[20] = c[7:0] ^ crc_xor;
    for (int k = first; k < n_bytes; k++) send_byte(fr[k], (k != bad_stop));
  endtask

  task automatic expect_commit(input rec_t r);
    exp_q.push_back(r);
    exp_pulses++;
  endtask

  task automatic check_held(input string tag);
    check({tag, "_motor"}, {24'd0, status_motor}, {24'd0, last_rec.motor});
    check({tag, "_p0"}, encoder0_position, last_rec.p0);
    check({tag, "_p1"}, encoder1_position, last_rec.p1);
    check({tag, "_v0"}, encoder0_velocity, last_rec.v0);
    check({tag, "_v1"}, encoder1_velocity, last_rec.v1);
  endtask

  // Monitor: received bytes and status pulses popped against the scoreboard.
  always @(negedge clk) begin
    if (dut.byte_valid === 1'b1) begin
      byte_cnt++;
      last_byte = dut.byte_data;
    end
    if (status_valid === 1'b1) begin
      rec_t r;
      pulses++;
      pulse_t = $time;
      tests++;
      assert (exp_q.size() > 0) else begin
        errs++;
        $error("FAIL unexpected_pulse: observed motor=%h expected no pulse", status_motor);
      end
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        last_rec = r;
        check("commit_motor", {24'd0, status_motor}, {24'd0, r.motor});
        check("commit_p0", encoder0_position, r.p0);
        check("commit_p1", encoder1_position, r.p1);
        check("commit_v0", encoder0_velocity, r.v0);
        check("commit_v1", encoder1_velocity, r.v1);
      end
    end
  end

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t r;
    int   d;
    rx_i  = 1'b1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_valid", {31'd0, status_valid}, 32'd0);
    check("rst_motor", {24'd0, status_motor}, 32'd0);
    check("rst_p0", encoder0_position, 32'd0);
    check("rst_p1", encoder1_position, 32'd0);
    check("rst_v0", encoder0_velocity, 32'd0);
    check("rst_v1", encoder1_velocity, 32'd0);
    check("rst_ok", {16'd0, frames_ok}, 32'd0);
    check("rst_bad", {16'd0, frames_bad}, 32'd0);
    reset = 1'b1;
    idle_bits(10);
    check("idle_pulses", pulses, 0);

    // Single 0xAA byte after reset
    send_byte(8'hAA, 1'b1);
    idle_bits(1);
    check("byte_count", byte_cnt, 1);
    check("byte_value", {24'd0, last_byte}, 32'h0000_00AA);

    // Good frame, ID 3
    r = '{8'd3, 32'h0000_0064, 32'hFFFF_FF9C, 32'h0000_0005, 32'h8000_0000};
    expect_commit(r);
    send_frame(8'd3, r.p0, r.p1, r.v0, r.v1, 8'h00, 0, 21, -1);
    idle_bits(2);
    check("good_pulses", pulses, exp_pulses);
    d = int'((pulse_t - stop_t) / 20);
    tests++;
    assert (d >= HALF + 3 && d <= HALF + 5) else begin
      errs++;
      $error("FAIL commit_latency: observed=%0d expected=%0d..%0d cycles", d, HALF + 3, HALF + 5);
    end
    check("good_enc1_neg", encoder1_position, -32'sd100);
    check("good_ok", {16'd0, frames_ok}, 32'd1);
    check("good_bad", {16'd0, frames_bad}, 32'd0);

    // Corrupted CRC low byte
    send_frame(8'd3, 32'h1111_1111, r.p1, r.v0, r.v1, 8'h01, 0, 21, -1);
    idle_bits(2);
    check("crc_pulses", pulses, exp_pulses);
    check("crc_bad", {16'd0, frames_bad}, 32'd1);
    check_held("crc_hold");

    // ID out of range
    send_frame(8'd8, r.p0, r.p1, r.v0, r.v1, 8'h00, 0, 21, -1);
    idle_bits(2);
    check("id_pulses", pulses, exp_pulses);
    check("id_bad", {16'd0, frames_bad}, 32'd2);
    check("id_ok", {16'd0, frames_ok}, 32'd1);

    // Noise, repeated 0xAA, then frame body
    send_byte(8'h13, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    r = '{8'd5, 32'h1234_5678, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0000_0001};
    expect_commit(r);
    send_frame(8'd5, r.p0, r.p1, r.v0, r.v1, 8'h00, 2, 21, -1);
    idle_bits(2);
    check("resync_pulses", pulses, exp_pulses);
    check("resync_ok", {16'd0, frames_ok}, 32'd2);

    // Line stalls after 10 payload bytes
    send_frame(8'd1, 32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10, 8'h00, 0, 13, -1);
    idle_bits(25);
    check("timeout_bad", {16'd0, frames_bad}, 32'd3);
    check("timeout_pulses", pulses, exp_pulses);
    check_held("timeout_hold");
    r = '{8'd0, 32'h7FFF_FFFF, 32'h8000_0001, 32'h0000_0000, 32'hFFFF_FF00};
    expect_commit(r);
    send_frame(8'd0, r.p0, r.p1, r.v0, r.v1, 8'h00, 0, 21, -1);
    idle_bits(2);
    check("after_timeout_ok", {16'd0, frames_ok}, 32'd3);
    check("after_timeout_pulses", pulses, exp_pulses);

    // Stop bit low inside the payload
    send_frame(8'd2, 32'h0A0B_0C0D, 32'h1020_3040, 32'h0000_1000, 32'h0000_2000, 8'h00, 0, 12, 11);
    idle_bits(3);
    check("framing_bad", {16'd0, frames_bad}, 32'd4);
    check("framing_pulses", pulses, exp_pulses);
    r = '{8'd7, 32'hCAFE_F00D, 32'h0000_0007, 32'hFFFF_FFF9, 32'h0001_0000};
    expect_commit(r);
    send_frame(8'd7, r.p0, r.p1, r.v0, r.v1, 8'h00, 0, 21, -1);
    idle_bits(2);
    check("after_framing_ok", {16'd0, frames_ok}, 32'd4);
    check("after_framing_bad", {16'd0, frames_bad}, 32'd4);
    check("after_framing_pulses", pulses, exp_pulses);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
